// File: rtl/pci_bus_arbiter_if.sv
// PCI arbiter bus bundle: request/grant lines plus the FRAME/IRDY pair
// the arbiter watches to track bus ownership.
// The device masters drive REQ/FRAME/IRDY through the 'master' modport.
// The arbiter returns GNT and ownership status through the 'slave' modport.
interface pci_bus_arbiter_if #(
    parameter int N = 4
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] REQ;
    logic         FRAME;
    logic         IRDY;
    logic [N-1:0] GNT;
    logic [W-1:0] OWNER;
    logic         OWNER_VALID;
    logic         TIMEOUT_EV;

    modport slave (
        input  REQ,
        input  FRAME,
        input  IRDY,
        output GNT,
        output OWNER,
        output OWNER_VALID,
        output TIMEOUT_EV
    );

    modport master (
        output REQ,
        output FRAME,
        output IRDY,
        input  GNT,
        input  OWNER,
        input  OWNER_VALID,
        input  TIMEOUT_EV
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Central round-robin PCI bus arbiter.
// Grants one active-low GNT at a time and follows FRAME/IRDY to see when a
// transaction starts and when the bus returns to idle. It revokes a grant
// whose owner fails to start FRAME within TIMEOUT cycles.
// Optional bus parking is enabled by defining the macro PCI_ARB_PARK_EN.
// With parking, an idle bus is granted to PARK_MASTER.
module pci_bus_arbiter #(
    parameter int N           = 4,
    parameter int TIMEOUT     = 16,
    parameter int PARK_MASTER = 0
) (
    input logic              i_clk,
    input logic              i_rst,
    pci_bus_arbiter_if.slave bus
);
    localparam int W  = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [W-1:0]  LAST_IDX    = W'(N - 1);
    localparam logic [CW-1:0] COUNT_LIMIT = CW'(TIMEOUT - 1);
`ifdef PCI_ARB_PARK_EN
    localparam logic [W-1:0]  PARK_IDX    = W'(PARK_MASTER);
`endif

    // A mis-sized arbiter would silently mis-index GNT, so reject it at elaboration
    if (N < 2 || N > 8) begin : g_badN
        $error("pci_bus_arbiter: N must be in 2..8");
    end
    if (PARK_MASTER < 0 || PARK_MASTER >= N) begin : g_badPark
        $error("pci_bus_arbiter: PARK_MASTER must be in 0..N-1");
    end
    if (TIMEOUT < 1) begin : g_badTimeout
        $error("pci_bus_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_ptr;
    logic [W-1:0]    r_owner;
    logic            r_ownerValid;
    logic [N-1:0]    r_gnt;
    logic [CW-1:0]   r_count;
    logic            r_timeoutEv;

    state_t          w_nextState;
    logic [W-1:0]    w_nextPtr;
    logic [W-1:0]    w_nextOwner;
    logic            w_nextOwnerValid;
    logic [N-1:0]    w_nextGnt;
    logic [CW-1:0]   w_nextCount;
    logic            w_nextTimeoutEv;

    logic            w_anyReq;
    logic [W-1:0]    w_winner;
    logic [W-1:0]    w_scanIdx;

    // Round-robin search starting just after the last owner, so that owner ranks last
    always_comb begin
        w_anyReq  = 1'b0;
        w_winner  = '0;
        w_scanIdx = '0;
        for (int k = 1; k <= N; k++) begin
            w_scanIdx = W'((int'(r_ptr) + k) % N);
            if (!w_anyReq && !bus.REQ[w_scanIdx]) begin
                w_anyReq = 1'b1;
                w_winner = w_scanIdx;
            end
        end
    end

    // Next-state and registered-output decode; GNT is only ever loaded from here
    always_comb begin
        w_nextState      = r_state;
        w_nextPtr        = r_ptr;
        w_nextOwner      = r_owner;
        w_nextOwnerValid = r_ownerValid;
        w_nextGnt        = '1;
        w_nextCount      = '0;
        w_nextTimeoutEv  = 1'b0;

        case (r_state)
            IDLE: begin
                w_nextOwnerValid = 1'b0;
`ifdef PCI_ARB_PARK_EN
                // A parked master may start a transaction without ever requesting
                if (!r_gnt[PARK_IDX] && !bus.FRAME) begin
                    w_nextState      = BUSY;
                    w_nextOwner      = PARK_IDX;
                    w_nextPtr        = PARK_IDX;
                    w_nextOwnerValid = 1'b1;
                end else if (w_anyReq) begin
                    w_nextState          = GRANT;
                    w_nextOwner          = w_winner;
                    w_nextOwnerValid     = 1'b1;
                    w_nextGnt[w_winner]  = 1'b0;
                end else begin
                    w_nextOwner          = PARK_IDX;
                    w_nextGnt[PARK_IDX]  = 1'b0;
                end
`else
                if (w_anyReq) begin
                    w_nextState          = GRANT;
                    w_nextOwner          = w_winner;
                    w_nextOwnerValid     = 1'b1;
                    w_nextGnt[w_winner]  = 1'b0;
                end
`endif
            end

            GRANT: begin
                if (!bus.FRAME) begin
                    w_nextState = BUSY;
                    w_nextPtr   = r_owner;
                end else if (bus.REQ[r_owner]) begin
                    w_nextState      = IDLE;
                    w_nextPtr        = r_owner;
                    w_nextOwnerValid = 1'b0;
                end else if (r_count == COUNT_LIMIT) begin
                    w_nextState      = IDLE;
                    w_nextPtr        = r_owner;
                    w_nextOwnerValid = 1'b0;
                    w_nextTimeoutEv  = 1'b1;
                end else begin
                    w_nextCount         = r_count + 1'b1;
                    w_nextGnt[r_owner]  = 1'b0;
                end
            end

            BUSY: begin
                if (bus.FRAME && bus.IRDY) begin
                    w_nextState      = IDLE;
                    w_nextOwnerValid = 1'b0;
                end
            end

            default: begin
                w_nextState      = IDLE;
                w_nextOwnerValid = 1'b0;
            end
        endcase
    end

    // State and output registers; the pointer resets to the top index so master 0 is searched first
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_ptr        <= LAST_IDX;
            r_owner      <= '0;
            r_ownerValid <= 1'b0;
            r_gnt        <= '1;
            r_count      <= '0;
            r_timeoutEv  <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_ptr        <= w_nextPtr;
            r_owner      <= w_nextOwner;
            r_ownerValid <= w_nextOwnerValid;
            r_gnt        <= w_nextGnt;
            r_count      <= w_nextCount;
            r_timeoutEv  <= w_nextTimeoutEv;
        end
    end

    assign bus.GNT         = r_gnt;
    assign bus.OWNER       = r_owner;
    assign bus.OWNER_VALID = r_ownerValid;
    assign bus.TIMEOUT_EV  = r_timeoutEv;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed testbench for pci_bus_arbiter (N=4, TIMEOUT=16, PARK_MASTER=3).
// The parking scenario is compiled in only when PCI_ARB_PARK_EN is defined.
module tb_pci_bus_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   testCount = 0;
    int   failCount = 0;

`ifdef PCI_ARB_PARK_EN
    localparam logic [3:0] IDLE_GNT   = 4'b0111;
    localparam logic [1:0] IDLE_OWNER = 2'd3;
`else
    localparam logic [3:0] IDLE_GNT   = 4'b1111;
    localparam logic [1:0] IDLE_OWNER = 2'd0;
`endif

    pci_bus_arbiter_if #(.N(4)) bus();

    pci_bus_arbiter #(
        .N(4),
        .TIMEOUT(16),
        .PARK_MASTER(3)
    ) dut (
        .i_clk(clock),
        .i_rst(reset),
        .bus(bus)
    );

    // Free-running bus clock
    always #5 clock = ~clock;

    // Packed view of the outputs: {GNT, OWNER, OWNER_VALID, TIMEOUT_EV}
    logic [7:0] observed;
    assign observed = {bus.GNT, bus.OWNER, bus.OWNER_VALID, bus.TIMEOUT_EV};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset();
        reset     = 1'b1;
        bus.REQ   = 4'b1111;
        bus.FRAME = 1'b1;
        bus.IRDY  = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        testCount++;
        if (observed !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL reset_values: got %b expected %b", observed, {4'b1111, 2'd0, 1'b0, 1'b0});
        end
        step();
        testCount++;
        if (observed !== {IDLE_GNT, IDLE_OWNER, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL idle_after_reset: got %b expected %b", observed, {IDLE_GNT, IDLE_OWNER, 1'b0, 1'b0});
        end
`ifndef PCI_ARB_PARK_EN
        bus.FRAME = 1'b0;
        step();
        testCount++;
        if (observed !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL frame_ignored_in_idle: got %b expected %b", observed, {4'b1111, 2'd0, 1'b0, 1'b0});
        end
        bus.FRAME = 1'b1;
        step();
`endif
    endtask

    task automatic test_basic_grant();
        applyReset();
        bus.REQ = 4'b1110;
        step();
        testCount++;
        if (observed !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL grant_latency: got %b expected %b", observed, {4'b1110, 2'd0, 1'b1, 1'b0});
        end
        step();
        testCount++;
        if (observed !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL grant_held: got %b expected %b", observed, {4'b1110, 2'd0, 1'b1, 1'b0});
        end
        bus.FRAME = 1'b0;
        step();
        testCount++;
        if (observed !== {4'b1111, 2'd0, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL frame_to_busy: got %b expected %b", observed, {4'b1111, 2'd0, 1'b1, 1'b0});
        end
        bus.REQ = 4'b1111;
        step();
        bus.FRAME = 1'b1;
        bus.IRDY  = 1'b0;
        step();
        testCount++;
        if (observed !== {4'b1111, 2'd0, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL irdy_holds_busy: got %b expected %b", observed, {4'b1111, 2'd0, 1'b1, 1'b0});
        end
        bus.IRDY = 1'b1;
        step();
        testCount++;
        if (observed !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL busy_to_idle: got %b expected %b", observed, {4'b1111, 2'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_round_robin();
        int expOwner[5] = '{0, 1, 2, 3, 0};
        applyReset();
        bus.REQ = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] expGnt;
            int waited;
            expGnt = 4'b1111;
            expGnt[expOwner[i]] = 1'b0;
            waited = 0;
            while (bus.GNT === 4'b1111 && waited < 10) begin
                step();
                waited++;
            end
            testCount++;
            if ({bus.GNT, bus.OWNER, bus.OWNER_VALID} !== {expGnt, 2'(expOwner[i]), 1'b1}) begin
                failCount++;
                $display("[TB] FAIL rr_order_%0d: got %b expected %b", i,
                         {bus.GNT, bus.OWNER, bus.OWNER_VALID}, {expGnt, 2'(expOwner[i]), 1'b1});
            end
            bus.FRAME = 1'b0;
            step();
            step();
            step();
            bus.FRAME = 1'b1;
            step();
            testCount++;
            if ({bus.GNT, bus.OWNER_VALID} !== {4'b1111, 1'b0}) begin
                failCount++;
                $display("[TB] FAIL rr_turnaround_%0d: got %b expected %b", i,
                         {bus.GNT, bus.OWNER_VALID}, {4'b1111, 1'b0});
            end
        end
        bus.REQ = 4'b1111;
        step();
        step();
    endtask

    task automatic test_timeout();
        int lowCount;
        applyReset();
        bus.REQ = 4'b1101;
        step();
        testCount++;
        if (observed !== {4'b1101, 2'd1, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL timeout_grant: got %b expected %b", observed, {4'b1101, 2'd1, 1'b1, 1'b0});
        end
        bus.REQ  = 4'b1100;
        lowCount = 1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.GNT === 4'b1101) lowCount++;
            else break;
        end
        testCount++;
        if (lowCount !== 16) begin
            failCount++;
            $display("[TB] FAIL timeout_grant_cycles: got %0d expected %0d", lowCount, 16);
        end
        testCount++;
        if (observed !== {4'b1111, 2'd1, 1'b0, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL timeout_revoke: got %b expected %b", observed, {4'b1111, 2'd1, 1'b0, 1'b1});
        end
        step();
        testCount++;
        if (observed !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL timeout_next_grant: got %b expected %b", observed, {4'b1110, 2'd0, 1'b1, 1'b0});
        end
        bus.REQ = 4'b1111;
        step();
        testCount++;
        if (observed !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL withdraw_revoke: got %b expected %b", observed, {4'b1111, 2'd0, 1'b0, 1'b0});
        end
        step();
    endtask

    task automatic test_frame_and_withdraw();
        applyReset();
        bus.REQ = 4'b1011;
        step();
        testCount++;
        if (observed !== {4'b1011, 2'd2, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL grant_master2: got %b expected %b", observed, {4'b1011, 2'd2, 1'b1, 1'b0});
        end
        bus.REQ   = 4'b1111;
        bus.FRAME = 1'b0;
        step();
        testCount++;
        if (observed !== {4'b1111, 2'd2, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL frame_beats_withdraw: got %b expected %b", observed, {4'b1111, 2'd2, 1'b1, 1'b0});
        end
        bus.FRAME = 1'b1;
        step();
        bus.REQ = 4'b0111;
        step();
        testCount++;
        if (observed !== {4'b0111, 2'd3, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL rr_after_master2: got %b expected %b", observed, {4'b0111, 2'd3, 1'b1, 1'b0});
        end
        bus.REQ = 4'b1111;
        step();
        testCount++;
        if (observed !== {4'b1111, 2'd3, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL plain_withdraw: got %b expected %b", observed, {4'b1111, 2'd3, 1'b0, 1'b0});
        end
        step();
    endtask

    task automatic test_reset_busy();
        applyReset();
        bus.REQ = 4'b0000;
        step();
        bus.FRAME = 1'b0;
        step();
        bus.FRAME = 1'b1;
        step();
        step();
        testCount++;
        if (observed !== {4'b1101, 2'd1, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL second_owner: got %b expected %b", observed, {4'b1101, 2'd1, 1'b1, 1'b0});
        end
        bus.FRAME = 1'b0;
        step();
        reset = 1'b1;
        step();
        testCount++;
        if (observed !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL reset_in_busy: got %b expected %b", observed, {4'b1111, 2'd0, 1'b0, 1'b0});
        end
        bus.FRAME = 1'b1;
        reset     = 1'b0;
        step();
        testCount++;
        if (observed !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL grant_after_reset: got %b expected %b", observed, {4'b1110, 2'd0, 1'b1, 1'b0});
        end
        bus.REQ = 4'b1111;
        step();
        step();
    endtask

`ifdef PCI_ARB_PARK_EN
    task automatic test_park();
        applyReset();
        step();
        testCount++;
        if (observed !== {4'b0111, 2'd3, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL park_grant: got %b expected %b", observed, {4'b0111, 2'd3, 1'b0, 1'b0});
        end
        bus.REQ = 4'b1011;
        step();
        testCount++;
        if (observed !== {4'b1011, 2'd2, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL park_override: got %b expected %b", observed, {4'b1011, 2'd2, 1'b1, 1'b0});
        end
        bus.REQ = 4'b1111;
        step();
        step();
        testCount++;
        if (observed !== {4'b0111, 2'd3, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL park_return: got %b expected %b", observed, {4'b0111, 2'd3, 1'b0, 1'b0});
        end
        bus.FRAME = 1'b0;
        step();
        testCount++;
        if (observed !== {4'b1111, 2'd3, 1'b1, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL park_frame_busy: got %b expected %b", observed, {4'b1111, 2'd3, 1'b1, 1'b0});
        end
        bus.FRAME = 1'b1;
        step();
    endtask
`endif

    // Scenario sequence followed by the single summary line
    initial begin
        bus.REQ   = 4'b1111;
        bus.FRAME = 1'b1;
        bus.IRDY  = 1'b1;
        test_reset();
        test_basic_grant();
        test_round_robin();
        test_timeout();
        test_frame_and_withdraw();
        test_reset_busy();
`ifdef PCI_ARB_PARK_EN
        test_park();
`endif
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
